// File: rtl/mant_div_seq.sv
// mant_div_seq: sequential restoring divider for floating-point mantissas.
// Produces one quotient bit per clock, MSB first, after a one-cycle capture.
// A zero divisor short-circuits straight to DONE with a saturated quotient.
// Optional feature macro: MANT_DIV_STICKY_EN (st = OR of final remainder);
// when undefined, st is tied low and no sticky logic is built.
module mant_div_seq #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz,
    output logic             st
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // dq starts out holding the dividend; each RUN cycle its MSB moves into
    // the partial remainder and a fresh quotient bit enters at the LSB, so
    // after WIDTH steps it holds exactly the quotient.
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   rem_wide;
    logic             carry;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dq_nxt;
    logic             last;
    logic             spare_unused;

    // One restoring step: shift in the next dividend bit and trial-subtract
    // the divisor as rem + ~b + 1; carry-out set means the difference is
    // non-negative and is kept, otherwise the shifted value is restored.
    always_comb begin
        shifted  = {rem, dq[WIDTH-1]};
        trial    = {1'b0, shifted} + {1'b0, ~{1'b0, dvs}} + {{(WIDTH+1){1'b0}}, 1'b1};
        carry    = trial[WIDTH+1];
        rem_wide = carry ? trial[WIDTH:0] : shifted;
        rem_nxt  = rem_wide[WIDTH-1:0];
        dq_nxt   = {dq[WIDTH-2:0], carry};
        last     = (cnt == CW'(1));
    end

    // The top bit of the selected remainder is always zero because the
    // remainder stays below the divisor; it is intentionally dropped.
    assign spare_unused = rem_wide[WIDTH];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status decode; start is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration registers and held results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            rem <= '0;
            dq  <= '0;
            dvs <= '0;
            q   <= '0;
            r   <= '0;
            dz  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            q  <= '1;
                            r  <= a;
                            dz <= 1'b1;
                        end else begin
                            dvs <= b;
                            dq  <= a;
                            rem <= '0;
                            cnt <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    dq  <= dq_nxt;
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        q  <= dq_nxt;
                        r  <= rem_nxt;
                        dz <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MANT_DIV_STICKY_EN
    // Sticky bit follows the remainder delivered with the result; for a zero
    // divisor the remainder is the dividend itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= 1'b0;
        end else if (state == IDLE && start && b == '0) begin
            st <= |a;
        end else if (state == RUN && last) begin
            st <= |rem_nxt;
        end
    end
`else
    assign st = 1'b0;
`endif

endmodule
